// File: rtl/stopwatch_lap_unit.sv
// SS.ss stopwatch with start/pause, zero-in-pause and a small lap store.
// Time is held as four BCD digits, so it can drive the shared display directly.
module stopwatch_lap_unit #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int TICK_HZ    = 100,
    parameter int LAP_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        push_m,
    input  logic        push_lap,
    input  logic        view_lap,
    input  logic [2:0]  lap_sel,
    output logic [15:0] segments,
    output logic [3:0]  lap_count,
    output logic        lap_full,
    output logic        running,
    output logic        overflow,
    output logic        finish
);

    localparam int PRESCALE = CLOCK_FREQ / TICK_HZ;
    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [3:0] DEPTH = 4'(LAP_DEPTH);

    typedef enum logic [1:0] {IDLE, READY, RUN, PAUSE} state_t;

    state_t          state, state_nx;
    logic [PW-1:0]   presc;
    logic [15:0]     time_bcd;
    logic [15:0]     lap_mem [8];
    logic [15:0]     lap_view;
    logic [15:0]     seg_p1;
    logic [16:0]     time_inc;
    logic            enable_q;
    logic            tick;
    logic            lap_wr;
    logic            zero_req;

    // Returns {carry_out, incremented value}; carry_out marks the 99.99 -> 00.00 wrap.
    function automatic logic [16:0] bcd_inc(input logic [15:0] t);
        logic [16:0] r;
        logic        carry;
        r     = '0;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry && t[i*4 +: 4] == 4'd9) begin
                r[i*4 +: 4] = 4'd0;
            end else if (carry) begin
                r[i*4 +: 4] = t[i*4 +: 4] + 4'd1;
                carry       = 1'b0;
            end else begin
                r[i*4 +: 4] = t[i*4 +: 4];
            end
        end
        r[16] = carry;
        return r;
    endfunction

    always_comb begin
        state_nx = state;
        if (!enable) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    state_nx = READY;
                READY:   if (push_m) state_nx = RUN;
                RUN:     if (push_m) state_nx = PAUSE;
                PAUSE:   if (push_m) state_nx = RUN;
                default: state_nx = IDLE;
            endcase
        end
    end

    // push_m wins over push_lap when both arrive together.
    assign tick     = enable && (state == RUN) && (presc == PRESC_LAST);
    assign lap_wr   = enable && (state == RUN) && push_lap && !push_m && (lap_count != DEPTH);
    assign zero_req = enable && (state == PAUSE) && push_lap && !push_m;
    assign time_inc = bcd_inc(time_bcd);

    always_comb begin
        lap_view = 16'h0000;
        if ({1'b0, lap_sel} < lap_count) begin
            lap_view = lap_mem[lap_sel];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            presc     <= '0;
            time_bcd  <= 16'h0000;
            overflow  <= 1'b0;
            lap_count <= 4'd0;
            lap_full  <= 1'b0;
            running   <= 1'b0;
            enable_q  <= 1'b0;
            finish    <= 1'b0;
            seg_p1    <= 16'h0000;
        end else begin
            state    <= state_nx;
            running  <= (state_nx == RUN);
            enable_q <= enable;
            finish   <= enable_q & ~enable;
            if (!enable) begin
                presc     <= '0;
                time_bcd  <= 16'h0000;
                overflow  <= 1'b0;
                lap_count <= 4'd0;
                lap_full  <= 1'b0;
            end else begin
                case (state)
                    READY: presc <= '0;
                    RUN: begin
                        presc <= tick ? '0 : presc + PW'(1);
                        if (tick) begin
                            time_bcd <= time_inc[15:0];
                            if (time_inc[16]) overflow <= 1'b1;
                        end
                        if (lap_wr) begin
                            lap_count <= lap_count + 4'd1;
                            lap_full  <= (lap_count + 4'd1 == DEPTH);
                        end
                    end
                    PAUSE: begin
                        if (zero_req) begin
                            presc    <= '0;
                            time_bcd <= 16'h0000;
                            overflow <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
            // display stage: one cycle behind time/lap selection
            seg_p1 <= view_lap ? lap_view : time_bcd;
        end
    end

    // Lap entries beyond lap_count are never shown, so the store needs no reset.
    always_ff @(posedge clk) begin
        if (lap_wr) begin
            lap_mem[lap_count[2:0]] <= time_bcd;
        end
    end

    assign segments = seg_p1;

endmodule
